// File: rtl/pipeline_hazard_ctl_pkg.sv
// Shared definitions for the decode/prelaunch hazard controller: FSM states,
// ins_flags bit positions, forward-select encoding and control-transfer decode.
package pipeline_hazard_ctl_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL     = 3'd0,
    ST_DATA_STALL = 3'd1,
    ST_MD_STALL   = 3'd2,
    ST_CONTROL    = 3'd3,
    ST_ISR_ENTER  = 3'd4
  } state_e;

  // ins_flags = {typeR_ALU, typeR_jr, typeI_ALU, typeI_Branch, typeI_Load, typeI_Store, typeJ, typeCP0_eret}
  localparam int FLAG_R_ALU    = 7;
  localparam int FLAG_R_JR     = 6;
  localparam int FLAG_I_ALU    = 5;
  localparam int FLAG_I_BRANCH = 4;
  localparam int FLAG_I_LOAD   = 3;
  localparam int FLAG_I_STORE  = 2;
  localparam int FLAG_J        = 1;
  localparam int FLAG_ERET     = 0;

  // fwd_sel value meaning "read the register file"; k+1 selects producer stage k
  localparam int FWD_SEL_GPR = 0;

  function automatic logic ctl_xfer(input logic jr, input logic j, input logic eret,
                                    input logic branch, input logic taken);
    return jr | j | eret | (branch & taken);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctl_if.sv
// Prelaunch-side bundle between the decode stage and the hazard controller.
// master = pipeline/decode driving instruction and producer info; slave = controller.
interface pipeline_hazard_ctl_if #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 3
);
  localparam int FSW = $clog2(FWD_STAGES + 1);

  logic [7:0]                   ins_flags;
  logic [NUM_SRC*REG_AW-1:0]    src_reg;
  logic [NUM_SRC-1:0]           src_valid;
  logic [FWD_STAGES*REG_AW-1:0] stage_reg_w;
  logic [FWD_STAGES-1:0]        stage_ready;
  logic [FWD_STAGES-1:0]        stage_kill;
  logic                         branch_result;
  logic                         md_start;
  logic                         md_use;
  logic                         IRQ;

  logic                         hazard_lock;
  logic [NUM_SRC*FSW-1:0]       fwd_sel;
  logic                         PC_use_PC_ctl;
  logic                         ISR_entering;
  logic                         ISR_leaving;
  logic                         md_busy;

  modport master (
    output ins_flags, src_reg, src_valid, stage_reg_w, stage_ready, stage_kill,
           branch_result, md_start, md_use, IRQ,
    input  hazard_lock, fwd_sel, PC_use_PC_ctl, ISR_entering, ISR_leaving, md_busy
  );

  modport slave (
    input  ins_flags, src_reg, src_valid, stage_reg_w, stage_ready, stage_kill,
           branch_result, md_start, md_use, IRQ,
    output hazard_lock, fwd_sel, PC_use_PC_ctl, ISR_entering, ISR_leaving, md_busy
  );

endinterface

// File: rtl/operand_fwd_match.sv
// One source operand: priority match against producer stages, nearest stage wins.
// Purely combinational; flags a data hazard when the winning stage is not ready.
module operand_fwd_match #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 3
) (
  input  logic [REG_AW-1:0]               src_reg,
  input  logic                            src_valid,
  input  logic [FWD_STAGES*REG_AW-1:0]    stage_reg_w,
  input  logic [FWD_STAGES-1:0]           stage_ready,
  input  logic [FWD_STAGES-1:0]           stage_kill,
  output logic [$clog2(FWD_STAGES+1)-1:0] fwd_sel,
  output logic                            data_hz
);
  localparam int FSW = $clog2(FWD_STAGES + 1);

  // Walk farthest to nearest so the lowest matching stage overwrites the rest;
  // an unready winner stalls even if a farther stage holds the same register.
  always_comb begin
    fwd_sel = '0;
    data_hz = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (src_valid && !stage_kill[k] &&
          stage_reg_w[k*REG_AW +: REG_AW] != '0 &&
          stage_reg_w[k*REG_AW +: REG_AW] == src_reg) begin
        fwd_sel = FSW'(k + 1);
        data_hz = ~stage_ready[k];
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctl.sv
// Launch/hazard controller at decode/prelaunch: forwarding select, data/mult-div stalls,
// post-branch flush and CP0 IRQ/eret handshakes. Outputs combinational from next state.
module pipeline_hazard_ctl
  import pipeline_hazard_ctl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int NUM_SRC      = 2,
  parameter int FWD_STAGES   = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int MD_CYCLES    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctl_if.slave bus
);
  localparam int FSW = $clog2(FWD_STAGES + 1);
  localparam int FLW = $clog2(FLUSH_CYCLES + 1);
  localparam int MDW = $clog2(MD_CYCLES + 1);

  logic [NUM_SRC*FSW-1:0] fwd_sel_raw;
  logic [NUM_SRC-1:0]     op_hz;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    operand_fwd_match #(
      .REG_AW     (REG_AW),
      .FWD_STAGES (FWD_STAGES)
    ) u_match (
      .src_reg     (bus.src_reg[i*REG_AW +: REG_AW]),
      .src_valid   (bus.src_valid[i]),
      .stage_reg_w (bus.stage_reg_w),
      .stage_ready (bus.stage_ready),
      .stage_kill  (bus.stage_kill),
      .fwd_sel     (fwd_sel_raw[i*FSW +: FSW]),
      .data_hz     (op_hz[i])
    );
  end

  state_e           state_q, state_d;
  logic [FLW-1:0]   flush_q, flush_d;
  logic [MDW-1:0]   md_cnt_q, md_cnt_d;
  logic             data_hz, md_busy_int, md_hz, ctl_hz, is_eret;
  logic             lock, pc_redirect, eret_leave;
  logic             unused_flags;

  assign data_hz     = |op_hz;
  assign md_busy_int = (md_cnt_q != '0);
  assign md_hz       = bus.md_use & md_busy_int;
  assign is_eret     = bus.ins_flags[FLAG_ERET];
  assign ctl_hz      = ctl_xfer(bus.ins_flags[FLAG_R_JR], bus.ins_flags[FLAG_J], is_eret,
                                bus.ins_flags[FLAG_I_BRANCH], bus.branch_result);
  assign unused_flags = ^{bus.ins_flags[FLAG_R_ALU], bus.ins_flags[FLAG_I_ALU],
                          bus.ins_flags[FLAG_I_LOAD], bus.ins_flags[FLAG_I_STORE]};

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    pc_redirect = 1'b0;
    eret_leave  = 1'b0;
    case (state_q)
      ST_CONTROL: begin
        if (flush_q != '0) begin
          flush_d = flush_q - FLW'(1);
        end else if (bus.IRQ) begin
          state_d = ST_ISR_ENTER;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_ISR_ENTER: state_d = ST_NORMAL;
      default: begin
        // Stalls outrank everything so an IRQ never splits a held instruction.
        if (data_hz) begin
          state_d = ST_DATA_STALL;
        end else if (md_hz) begin
          state_d = ST_MD_STALL;
        end else if (ctl_hz) begin
          state_d     = ST_CONTROL;
          flush_d     = FLW'(FLUSH_CYCLES - 1);
          eret_leave  = is_eret;
          pc_redirect = ~is_eret;
        end else if (bus.IRQ) begin
          state_d = ST_ISR_ENTER;
        end else begin
          state_d = ST_NORMAL;
        end
      end
    endcase
  end

  assign lock = (state_d != ST_NORMAL);

  // A mult/div held by a stall is not issued yet, so it must not restart the unit.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (bus.md_start && !lock) begin
      md_cnt_d = MDW'(MD_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_NORMAL;
      flush_q  <= '0;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign bus.hazard_lock   = rst_n & lock;
  assign bus.fwd_sel       = rst_n ? fwd_sel_raw : '0;
  assign bus.PC_use_PC_ctl = rst_n & pc_redirect;
  assign bus.ISR_leaving   = rst_n & eret_leave;
  assign bus.ISR_entering  = rst_n & (state_d == ST_ISR_ENTER);
  assign bus.md_busy       = rst_n & md_busy_int;

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Directed plus random stimulus for pipeline_hazard_ctl, checked against a
// cycle-stamp reference model of stalls, flush windows and mult/div occupancy.
module tb_pipeline_hazard_ctl;
  localparam int REG_AW       = 5;
  localparam int NUM_SRC      = 2;
  localparam int FWD_STAGES   = 3;
  localparam int FLUSH_CYCLES = 2;
  localparam int MD_CYCLES    = 4;
  localparam int FSW          = $clog2(FWD_STAGES + 1);

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctl_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES)) bus ();

  pipeline_hazard_ctl #(
    .REG_AW       (REG_AW),
    .NUM_SRC      (NUM_SRC),
    .FWD_STAGES   (FWD_STAGES),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .MD_CYCLES    (MD_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state, kept as absolute cycle stamps.
  bit in_ctl, in_isr;
  int ctl_until, md_free_at;

  logic                   e_lock, e_pc, e_leave, e_isr, e_busy;
  logic [NUM_SRC*FSW-1:0] e_fwd;
  bit                     e_enter_ctl, e_nxt_ctl, e_nxt_isr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ins_flags     = '0;
    bus.src_reg       = '0;
    bus.src_valid     = '0;
    bus.stage_reg_w   = '0;
    bus.stage_ready   = '1;
    bus.stage_kill    = '0;
    bus.branch_result = 1'b0;
    bus.md_start      = 1'b0;
    bus.md_use        = 1'b0;
    bus.IRQ           = 1'b0;
  endtask

  task automatic model_reset();
    in_ctl     = 1'b0;
    in_isr     = 1'b0;
    ctl_until  = 0;
    md_free_at = cyc;
  endtask

  task automatic model_eval();
    bit dhz, mhz, chz, hit;
    logic [REG_AW-1:0] sreg, wreg;
    e_fwd = '0;
    dhz   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit  = 1'b0;
      sreg = bus.src_reg[i*REG_AW +: REG_AW];
      for (int k = 0; k < FWD_STAGES; k++) begin
        wreg = bus.stage_reg_w[k*REG_AW +: REG_AW];
        if (!hit && bus.src_valid[i] && wreg != 0 && wreg == sreg && !bus.stage_kill[k]) begin
          hit = 1'b1;
          e_fwd[i*FSW +: FSW] = FSW'(k + 1);
          if (!bus.stage_ready[k]) dhz = 1'b1;
        end
      end
    end
    e_busy = (cyc < md_free_at);
    mhz    = bus.md_use && e_busy;
    chz    = bus.ins_flags[6] || bus.ins_flags[1] || bus.ins_flags[0] ||
             (bus.ins_flags[4] && bus.branch_result);
    e_lock = 0; e_pc = 0; e_leave = 0; e_isr = 0;
    e_enter_ctl = 0; e_nxt_ctl = 0; e_nxt_isr = 0;
    if (in_isr) begin
      // one ISR-entry cycle then straight back to normal issue
    end else if (in_ctl) begin
      if (cyc < ctl_until) begin
        e_lock = 1; e_nxt_ctl = 1;
      end else if (bus.IRQ) begin
        e_lock = 1; e_isr = 1; e_nxt_isr = 1;
      end
    end else if (dhz || mhz) begin
      e_lock = 1;
    end else if (chz) begin
      e_lock = 1; e_nxt_ctl = 1; e_enter_ctl = 1;
      if (bus.ins_flags[0]) e_leave = 1;
      else e_pc = 1;
    end else if (bus.IRQ) begin
      e_lock = 1; e_isr = 1; e_nxt_isr = 1;
    end
  endtask

  task automatic model_commit();
    if (e_enter_ctl) ctl_until = cyc + FLUSH_CYCLES;
    in_ctl = e_nxt_ctl;
    in_isr = e_nxt_isr;
    if (bus.md_start && !e_lock) md_free_at = cyc + 1 + MD_CYCLES;
    cyc++;
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, ".lock"},  bus.hazard_lock,   e_lock);
    chk({tag, ".fwd"},   bus.fwd_sel,       e_fwd);
    chk({tag, ".pc"},    bus.PC_use_PC_ctl, e_pc);
    chk({tag, ".leave"}, bus.ISR_leaving,   e_leave);
    chk({tag, ".isr"},   bus.ISR_entering,  e_isr);
    chk({tag, ".busy"},  bus.md_busy,       e_busy);
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".lock"},  bus.hazard_lock,   0);
    chk({tag, ".fwd"},   bus.fwd_sel,       0);
    chk({tag, ".pc"},    bus.PC_use_PC_ctl, 0);
    chk({tag, ".leave"}, bus.ISR_leaving,   0);
    chk({tag, ".isr"},   bus.ISR_entering,  0);
    chk({tag, ".busy"},  bus.md_busy,       0);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    // inputs that would otherwise forward, redirect and take an IRQ
    bus.src_reg       = {5'd0, 5'd8};
    bus.src_valid     = 2'b01;
    bus.stage_reg_w   = {5'd0, 5'd0, 5'd8};
    bus.ins_flags     = 8'h10;
    bus.branch_result = 1'b1;
    bus.IRQ           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    model_reset();

    // nearest of two matching stages forwards
    bus.src_reg     = {5'd0, 5'd8};
    bus.src_valid   = 2'b01;
    bus.stage_reg_w = {5'd0, 5'd8, 5'd8};
    sample("t1");
    chk("t1.fwd0", bus.fwd_sel[FSW-1:0], 1);
    chk("t1.nolock", bus.hazard_lock, 0);
    advance();

    // load-use: unready stage 0 stalls, then forwards from stage 1
    bus.src_reg     = {5'd9, 5'd0};
    bus.src_valid   = 2'b10;
    bus.stage_reg_w = {5'd0, 5'd0, 5'd9};
    bus.stage_ready = 3'b110;
    sample("t2a");
    chk("t2a.stall", bus.hazard_lock, 1);
    advance();
    bus.stage_reg_w = {5'd0, 5'd9, 5'd0};
    bus.stage_ready = 3'b111;
    sample("t2b");
    chk("t2b.fwd1", bus.fwd_sel[2*FSW-1:FSW], 2);
    chk("t2b.nolock", bus.hazard_lock, 0);
    advance();
    // no fallback to a ready farther stage
    bus.stage_reg_w = {5'd0, 5'd9, 5'd9};
    bus.stage_ready = 3'b110;
    sample("t2c");
    chk("t2c.stall", bus.hazard_lock, 1);
    chk("t2c.fwd1", bus.fwd_sel[2*FSW-1:FSW], 1);
    advance();
    // killed stage is skipped
    bus.stage_kill = 3'b001;
    sample("t2d");
    chk("t2d.fwd1", bus.fwd_sel[2*FSW-1:FSW], 2);
    chk("t2d.nolock", bus.hazard_lock, 0);
    advance();
    clear_inputs();

    // taken branch: redirect pulse and FLUSH_CYCLES of lock
    bus.ins_flags     = 8'h10;
    bus.branch_result = 1'b1;
    sample("t3a");
    chk("t3a.pc", bus.PC_use_PC_ctl, 1);
    advance();
    clear_inputs();
    sample("t3b");
    chk("t3b.pc", bus.PC_use_PC_ctl, 0);
    chk("t3b.lock", bus.hazard_lock, 1);
    advance();
    sample("t3c");
    chk("t3c.lock", bus.hazard_lock, 0);
    advance();
    bus.ins_flags = 8'h10;
    sample("t3d");
    chk("t3d.nottaken", bus.hazard_lock, 0);
    advance();
    clear_inputs();

    // mult/div occupancy, with a second start while busy that must not reload
    bus.md_start = 1'b1;
    bus.md_use   = 1'b1;
    sample("t4s");
    chk("t4s.lock", bus.hazard_lock, 0);
    advance();
    for (int j = 1; j <= MD_CYCLES + 1; j++) begin
      bus.md_start = (j == 2);
      sample("t4");
      chk("t4.lock", bus.hazard_lock, (j <= MD_CYCLES) ? 1 : 0);
      chk("t4.busy", bus.md_busy, (j <= MD_CYCLES) ? 1 : 0);
      advance();
    end
    clear_inputs();

    // IRQ held off by a data stall, then eret
    bus.src_reg     = {5'd9, 5'd0};
    bus.src_valid   = 2'b10;
    bus.stage_reg_w = {5'd0, 5'd0, 5'd9};
    bus.stage_ready = 3'b110;
    bus.IRQ         = 1'b1;
    repeat (2) begin
      sample("t5a");
      chk("t5a.isr", bus.ISR_entering, 0);
      advance();
    end
    bus.stage_ready = 3'b111;
    sample("t5b");
    chk("t5b.isr", bus.ISR_entering, 1);
    advance();
    clear_inputs();
    sample("t5c");
    chk("t5c.lock", bus.hazard_lock, 0);
    advance();
    bus.ins_flags = 8'h01;
    sample("t5d");
    chk("t5d.leave", bus.ISR_leaving, 1);
    chk("t5d.pc", bus.PC_use_PC_ctl, 0);
    advance();
    clear_inputs();
    sample("t5e");
    advance();
    sample("t5f");
    advance();

    // async reset in the middle of a flush with the mult/div busy
    bus.md_start = 1'b1;
    bus.md_use   = 1'b1;
    sample("t6a");
    advance();
    clear_inputs();
    bus.ins_flags = 8'h02;
    sample("t6b");
    chk("t6b.pc", bus.PC_use_PC_ctl, 1);
    advance();
    bus.IRQ = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6rst");
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sample("t6c");
    chk("t6c.lock", bus.hazard_lock, 0);
    chk("t6c.busy", bus.md_busy, 0);
    advance();

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 11);
      bus.ins_flags     = (r < 8) ? 8'(1 << r) : 8'h00;
      bus.branch_result = 1'($urandom_range(0, 1));
      for (int i = 0; i < NUM_SRC; i++)
        bus.src_reg[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
      bus.src_valid = NUM_SRC'($urandom_range(0, 3));
      for (int k = 0; k < FWD_STAGES; k++) begin
        bus.stage_reg_w[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
        bus.stage_ready[k] = ($urandom_range(0, 3) != 0);
        bus.stage_kill[k]  = ($urandom_range(0, 7) == 0);
      end
      bus.IRQ      = ($urandom_range(0, 7) == 0);
      bus.md_start = ($urandom_range(0, 15) == 0);
      bus.md_use   = bus.md_start || ($urandom_range(0, 5) == 0);
      sample("rnd");
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
